// File: rtl/prio_encoder_latched.sv
// Registered priority encoder with sticky request capture and a valid/ready
// output port. Each request is held in a pending register until its index has
// been offered and accepted. The winner is the highest index (MODE=0) or comes
// from a descending round-robin search (MODE=1).
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no offer outstanding; out_valid=0, out_idx all-ones
// OFFER | out_idx holds a pending request; held until out_ready accepts it
module prio_encoder_latched #(
    parameter int N    = 10,
    parameter int W    = $clog2(N),
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pending
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [W-1:0] idx_d;
    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;
    logic [N-1:0] pend_d;
    logic [N-1:0] req_eff;
    logic [N-1:0] gmask;
    logic [N-1:0] cand;
    logic [W-1:0] sel_idx;
    logic         grant;

    // Highest set index wins. The legacy 10-to-4 encoder used the same ordering.
    function automatic logic [W-1:0] sel_fixed(input logic [N-1:0] c);
        logic [W-1:0] r;
        r = '1;
        for (int k = 0; k < N; k++) begin
            if (c[k]) r = W'(k);
        end
        return r;
    endfunction

    // Descending search that starts one below the pointer and wraps from 0 to
    // N-1. The pointer itself is visited last, so it has the lowest priority.
    function automatic logic [W-1:0] sel_rr(input logic [N-1:0] c,
                                            input logic [W-1:0] p);
        logic [W-1:0] r;
        logic         found;
        int           j;
        r     = '1;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            j = int'(p) - k;
            if (j < 0) j = j + N;
            if (!found && c[j]) begin
                r     = W'(j);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign out_valid = (state_q == OFFER);
    assign req_eff   = en ? req : '0;
    assign grant     = out_valid & out_ready;
    // A granted index is removed from the candidates in its grant cycle, so a
    // single request can never be offered twice.
    assign gmask     = grant ? (N'(1) << out_idx) : '0;
    assign cand      = (pending | req_eff) & ~gmask;
    assign sel_idx   = (MODE == 1) ? sel_rr(cand, ptr_q) : sel_fixed(cand);

    // Next state, next offer, pointer and pending update.
    always_comb begin
        state_d = state_q;
        idx_d   = out_idx;
        ptr_d   = ptr_q;
        // A new request on the granted bit re-arms it (set wins over clear).
        pend_d  = (pending & ~gmask) | req_eff;

        if (grant) ptr_d = out_idx;

        unique case (state_q)
            IDLE: begin
                if (|cand) begin
                    state_d = OFFER;
                    idx_d   = sel_idx;
                end
            end
            OFFER: begin
                // Without a grant the offer is frozen, even if a higher
                // priority request arrives.
                if (grant) begin
                    if (|cand) begin
                        state_d = OFFER;
                        idx_d   = sel_idx;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '1;
            end
        endcase
    end

    // State register. Reset also aborts an offer that is in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_idx <= '1;
            pending <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            out_idx <= idx_d;
            pending <= pend_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_prio_encoder_latched.sv
// Bench for prio_encoder_latched. It runs a fixed-priority and a round-robin
// instance side by side on the same stimulus. The first part applies directed
// vectors. A hand-written backpressure sequence follows, then randomized
// traffic. On every cycle both instances are also compared with a reference
// model that works on arrays.
module tb_prio_encoder_latched;

    localparam int N = 10;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         out_ready;
    logic [N-1:0] req;
    logic [W-1:0] idx0, idx1;
    logic         v0, v1;
    logic [N-1:0] p0, p1;

    always #5 clk = ~clk;

    prio_encoder_latched #(.N(N), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .out_idx(idx0), .out_valid(v0), .out_ready(out_ready), .pending(p0)
    );

    prio_encoder_latched #(.N(N), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .out_idx(idx1), .out_valid(v1), .out_ready(out_ready), .pending(p1)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t",
                      name, act, exp, $time);
    endtask

    // Reference model: index 0 is fixed priority, index 1 is round-robin.
    bit mpend [2][N];
    bit mvalid[2];
    int midx  [2];
    int mptr  [2];

    function automatic void model_reset(int m);
        for (int i = 0; i < N; i++) mpend[m][i] = 1'b0;
        mvalid[m] = 1'b0;
        midx[m]   = -1;
        mptr[m]   = 0;
    endfunction

    function automatic void model_step(int m);
        bit cand[N];
        bit g_on, r;
        int g, best, bestrank, rank, s;
        if (rst) begin
            model_reset(m);
            return;
        end
        g_on = mvalid[m] && out_ready;
        g    = g_on ? midx[m] : -1;
        for (int i = 0; i < N; i++) begin
            r = en && req[i];
            cand[i]     = (mpend[m][i] || r) && (i != g);
            mpend[m][i] = (mpend[m][i] && (i != g)) || r;
        end
        // Rank 0 is the most favoured line.
        s        = (mptr[m] + N - 1) % N;
        best     = -1;
        bestrank = N;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) begin
                rank = (m == 0) ? (N - 1 - i) : ((s - i + N) % N);
                if (rank < bestrank) begin
                    bestrank = rank;
                    best     = i;
                end
            end
        end
        if (g_on) mptr[m] = midx[m];
        if (!mvalid[m] || g_on) begin
            mvalid[m] = (best >= 0);
            midx[m]   = best;
        end
    endfunction

    task automatic check_model(input int m);
        logic [N-1:0] ep;
        logic [W-1:0] ei;
        for (int i = 0; i < N; i++) ep[i] = mpend[m][i];
        ei = mvalid[m] ? W'(midx[m]) : '1;
        if (m == 0) begin
            check("model0_valid", 64'(v0), 64'(mvalid[0]));
            check("model0_idx", 64'(idx0), 64'(ei));
            check("model0_pending", 64'(p0), 64'(ep));
        end else begin
            check("model1_valid", 64'(v1), 64'(mvalid[1]));
            check("model1_idx", 64'(idx1), 64'(ei));
            check("model1_pending", 64'(p1), 64'(ep));
        end
    endtask

    // One clock: the model steps on the edge, and both instances are compared 1ns later.
    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_model(0);
        check_model(1);
    endtask

    typedef struct {
        bit           r;
        bit           e;
        logic [N-1:0] q;
        bit           rdy;
        int           dut;
        bit           ev;
        logic [W-1:0] ei;
        logic [N-1:0] ep;
    } vec_t;

    vec_t vt[$];

    function automatic void add(bit r, bit e, logic [N-1:0] q, bit rdy, int dut,
                                bit ev, logic [W-1:0] ei, logic [N-1:0] ep);
        vec_t v;
        v.r = r; v.e = e; v.q = q; v.rdy = rdy; v.dut = dut;
        v.ev = ev; v.ei = ei; v.ep = ep;
        vt.push_back(v);
    endfunction

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        model_reset(0);
        model_reset(1);

        // Reset with all requests asserted, then release.
        add(1, 1, 10'h3FF, 0, 0, 0, 4'hF, 10'h000);
        add(1, 1, 10'h3FF, 0, 0, 0, 4'hF, 10'h000);
        add(0, 1, 10'h3FF, 0, 0, 1, 4'd9, 10'h3FF);
        add(1, 1, 10'h000, 0, 0, 0, 4'hF, 10'h000);
        // Fixed priority, ready held: 5, 2, 0, then idle.
        add(0, 1, 10'h025, 1, 0, 1, 4'd5, 10'h025);
        add(0, 1, 10'h000, 1, 0, 1, 4'd2, 10'h005);
        add(0, 1, 10'h000, 1, 0, 1, 4'd0, 10'h001);
        add(0, 1, 10'h000, 1, 0, 0, 4'hF, 10'h000);
        // Backpressure: the offer of 3 stays while 8 queues behind it.
        add(0, 1, 10'h008, 0, 0, 1, 4'd3, 10'h008);
        add(0, 1, 10'h100, 0, 0, 1, 4'd3, 10'h108);
        add(0, 1, 10'h000, 0, 0, 1, 4'd3, 10'h108);
        add(0, 1, 10'h000, 1, 0, 1, 4'd8, 10'h100);
        add(0, 1, 10'h000, 1, 0, 0, 4'hF, 10'h000);
        // Set wins: a request on bit 4 in its grant cycle re-arms it.
        add(0, 1, 10'h010, 0, 0, 1, 4'd4, 10'h010);
        add(0, 1, 10'h010, 1, 0, 0, 4'hF, 10'h010);
        add(0, 1, 10'h000, 1, 0, 1, 4'd4, 10'h010);
        add(0, 1, 10'h000, 1, 0, 0, 4'hF, 10'h000);
        // While en=0, requests are ignored.
        add(0, 0, 10'h3FF, 1, 0, 0, 4'hF, 10'h000);
        add(0, 1, 10'h001, 0, 0, 1, 4'd0, 10'h001);
        add(0, 0, 10'h3FE, 0, 0, 1, 4'd0, 10'h001);
        // Reset during a stalled offer.
        add(1, 1, 10'h000, 0, 0, 0, 4'hF, 10'h000);
        add(0, 1, 10'h000, 0, 1, 0, 4'hF, 10'h000);
        // Round-robin with all lines held: 9 down to 0, then wrap to 9.
        for (int k = 0; k < 11; k++)
            add(0, 1, 10'h3FF, 1, 1, 1, (k < 10) ? W'(9 - k) : W'(9), 10'h3FF);
        add(1, 1, 10'h000, 1, 1, 0, 4'hF, 10'h000);
        // Round-robin with lines 9 and 2 held: they alternate.
        for (int k = 0; k < 4; k++)
            add(0, 1, 10'h204, 1, 1, 1, (k % 2 == 0) ? W'(9) : W'(2), 10'h204);
        add(1, 1, 10'h000, 1, 1, 0, 4'hF, 10'h000);

        for (int i = 0; i < vt.size(); i++) begin
            rst       = vt[i].r;
            en        = vt[i].e;
            req       = vt[i].q;
            out_ready = vt[i].rdy;
            cycle();
            if (vt[i].dut == 0) begin
                check($sformatf("vec%0d_valid", i), 64'(v0), 64'(vt[i].ev));
                check($sformatf("vec%0d_idx", i), 64'(idx0), 64'(vt[i].ei));
                check($sformatf("vec%0d_pending", i), 64'(p0), 64'(vt[i].ep));
            end else begin
                check($sformatf("vec%0d_valid", i), 64'(v1), 64'(vt[i].ev));
                check($sformatf("vec%0d_idx", i), 64'(idx1), 64'(vt[i].ei));
                check($sformatf("vec%0d_pending", i), 64'(p1), 64'(vt[i].ep));
            end
        end

        // Offer of line 1 under a long stall, with higher lines arriving.
        rst = 1'b0; en = 1'b1; out_ready = 1'b0;
        req = 10'h002;
        cycle();
        for (int k = 0; k < 6; k++) begin
            req = N'($urandom) & 10'h3FC;
            cycle();
            check("stall_idx0", 64'(idx0), 64'd1);
            check("stall_idx1", 64'(idx1), 64'd1);
            check("stall_valid", 64'({v0, v1}), 64'b11);
        end
        req = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) cycle();
        check("drain_pending0", 64'(p0), 64'd0);
        check("drain_pending1", 64'(p1), 64'd0);

        // Randomized traffic checked against the model.
        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 59) == 0);
            en        = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 9) == 0) req = N'($urandom);
            else req = N'($urandom & $urandom & $urandom);
            out_ready = ($urandom_range(0, 99) < 60);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
